psum_addr_gen: RTL and testbench

Multi-pass address generator for the PE partial-sum scratchpad; successor to the plain psum counter.
- Produces a strided read-address stream over a programmable window (base, length, stride), repeated for a programmable number of accumulation passes.
- Produces a matching write-address stream delayed by the accumulator latency.
- Flags the first and last pass, and signals completion only after the final write has left the pipeline.

---
 rtl/psum_addr_gen.sv | 201 ++++++++++++++++++++
 tb/tb_psum_addr_gen.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/psum_addr_gen.sv
// Multi-pass strided address generator for the PE partial-sum scratchpad.
// Optional bounds check on the configured window is enabled by PSUM_ADDR_GEN_BOUNDS_EN.
module psum_addr_gen #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned LEN_W  = 8,
  parameter int unsigned PASS_W = 4,
  parameter int unsigned WR_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] cfg_base,
  input  logic [LEN_W-1:0]  cfg_len,
  input  logic [ADDR_W-1:0] cfg_stride,
  input  logic [PASS_W-1:0] cfg_passes,
  input  logic              step,
  output logic              rd_valid,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              first_pass,
  output logic              last_pass,
  output logic              wr_valid,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] base_q, base_nxt;
  logic [ADDR_W-1:0] stride_q, stride_nxt;
  logic [LEN_W-1:0]  len_q, len_nxt;
  logic [PASS_W-1:0] passes_q, passes_nxt;
  logic [ADDR_W-1:0] rd_addr_nxt;
  logic [LEN_W-1:0]  idx, idx_nxt;
  logic [PASS_W-1:0] pass, pass_nxt;
  logic              done_nxt;
  logic              push_c;
  logic              bounds_fail_c;
  logic              start_ok_c;

  logic [WR_LAT-1:0] pipe_valid, pipe_valid_nxt;
  logic [ADDR_W-1:0] pipe_addr     [WR_LAT];
  logic [ADDR_W-1:0] pipe_addr_nxt [WR_LAT];

  assign start_ok_c = (state == IDLE) && start && !abort;
  assign push_c     = (state == RUN) && step && !abort;
  assign wr_valid   = pipe_valid[WR_LAT-1];
  assign wr_addr    = pipe_addr[WR_LAT-1];

`ifdef PSUM_ADDR_GEN_BOUNDS_EN
  localparam int unsigned EXT_W = ADDR_W + LEN_W + 1;

  logic [LEN_W-1:0] len_m1_c;
  logic [EXT_W-1:0] end_c;

  // Last address of the window without wrap; refuse if it leaves the scratchpad.
  always_comb begin
    len_m1_c      = cfg_len - 1'b1;
    end_c         = EXT_W'(cfg_base) + EXT_W'(len_m1_c) * EXT_W'(cfg_stride);
    bounds_fail_c = (cfg_len != '0) && (cfg_passes != '0) &&
                    (end_c[EXT_W-1:ADDR_W] != '0);
  end

  // Sticky until reset or the next accepted start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err <= 1'b0;
    end else if (start_ok_c) begin
      err <= bounds_fail_c;
    end
  end
`else
  assign bounds_fail_c = 1'b0;
  assign err           = 1'b0;
`endif

  // Write pipeline shifts every cycle; bubbles carry a zero address.
  always_comb begin
    pipe_valid_nxt = '0;
    for (int unsigned k = 0; k < WR_LAT; k++) begin
      pipe_addr_nxt[k] = '0;
    end
    pipe_valid_nxt[0] = push_c;
    pipe_addr_nxt[0]  = push_c ? rd_addr : '0;
    for (int unsigned k = 1; k < WR_LAT; k++) begin
      pipe_valid_nxt[k] = pipe_valid[k-1];
      pipe_addr_nxt[k]  = pipe_addr[k-1];
    end
    if (abort) begin
      pipe_valid_nxt = '0;
      for (int unsigned k = 0; k < WR_LAT; k++) begin
        pipe_addr_nxt[k] = '0;
      end
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_nxt   = state;
    base_nxt    = base_q;
    stride_nxt  = stride_q;
    len_nxt     = len_q;
    passes_nxt  = passes_q;
    rd_addr_nxt = rd_addr;
    idx_nxt     = idx;
    pass_nxt    = pass;
    done_nxt    = 1'b0;

    case (state)
      IDLE: begin
        if (start_ok_c && !bounds_fail_c) begin
          base_nxt    = cfg_base;
          stride_nxt  = cfg_stride;
          len_nxt     = cfg_len;
          passes_nxt  = cfg_passes;
          rd_addr_nxt = cfg_base;
          idx_nxt     = '0;
          pass_nxt    = '0;
          state_nxt   = ((cfg_len == '0) || (cfg_passes == '0)) ? DRAIN : RUN;
        end
      end
      RUN: begin
        if (step) begin
          if (idx == len_q - 1'b1) begin
            idx_nxt     = '0;
            rd_addr_nxt = base_q;
            if (pass == passes_q - 1'b1) begin
              state_nxt = DRAIN;
            end else begin
              pass_nxt = pass + 1'b1;
            end
          end else begin
            idx_nxt     = idx + 1'b1;
            rd_addr_nxt = rd_addr + stride_q;
          end
        end
      end
      DRAIN: begin
        if (pipe_valid_nxt == '0) begin
          done_nxt  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase

    if (abort) begin
      state_nxt   = IDLE;
      rd_addr_nxt = '0;
      idx_nxt     = '0;
      pass_nxt    = '0;
      done_nxt    = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      base_q     <= '0;
      stride_q   <= '0;
      len_q      <= '0;
      passes_q   <= '0;
      rd_addr    <= '0;
      idx        <= '0;
      pass       <= '0;
      done       <= 1'b0;
      rd_valid   <= 1'b0;
      busy       <= 1'b0;
      first_pass <= 1'b0;
      last_pass  <= 1'b0;
      pipe_valid <= '0;
      for (int unsigned k = 0; k < WR_LAT; k++) begin
        pipe_addr[k] <= '0;
      end
    end else begin
      state      <= state_nxt;
      base_q     <= base_nxt;
      stride_q   <= stride_nxt;
      len_q      <= len_nxt;
      passes_q   <= passes_nxt;
      rd_addr    <= rd_addr_nxt;
      idx        <= idx_nxt;
      pass       <= pass_nxt;
      done       <= done_nxt;
      rd_valid   <= (state_nxt == RUN);
      busy       <= (state_nxt != IDLE);
      first_pass <= (state_nxt == RUN) && (pass_nxt == '0);
      last_pass  <= (state_nxt == RUN) && (pass_nxt == passes_nxt - 1'b1);
      pipe_valid <= pipe_valid_nxt;
      pipe_addr  <= pipe_addr_nxt;
    end
  end

endmodule

// File: tb/tb_psum_addr_gen.sv
// Self-checking bench for psum_addr_gen: config table plus abort/reset sequences.
module tb_psum_addr_gen;

  localparam int unsigned ADDR_W = 8;
  localparam int unsigned LEN_W  = 8;
  localparam int unsigned PASS_W = 4;
  localparam int unsigned WR_LAT = 2;
  localparam int          BUDGET = 400;

  logic              clk = 1'b0;
  logic              rst;
  logic              start, abort, step;
  logic [ADDR_W-1:0] cfg_base, cfg_stride;
  logic [LEN_W-1:0]  cfg_len;
  logic [PASS_W-1:0] cfg_passes;
  logic              rd_valid, first_pass, last_pass, wr_valid, busy, done, err;
  logic [ADDR_W-1:0] rd_addr, wr_addr;

  psum_addr_gen #(
    .ADDR_W(ADDR_W), .LEN_W(LEN_W), .PASS_W(PASS_W), .WR_LAT(WR_LAT)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .cfg_base(cfg_base), .cfg_len(cfg_len), .cfg_stride(cfg_stride),
    .cfg_passes(cfg_passes), .step(step),
    .rd_valid(rd_valid), .rd_addr(rd_addr), .first_pass(first_pass),
    .last_pass(last_pass), .wr_valid(wr_valid), .wr_addr(wr_addr),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // mode: 0 = step held high, 1 = step toggling 1,0,..., 2 = random step with noisy cfg/start
  typedef struct {
    logic [7:0] base;
    logic [7:0] len;
    logic [7:0] stride;
    logic [3:0] passes;
    int         mode;
    bit         refuse;
    int         exp_reads;
    logic [7:0] exp_last;
  } vec_t;

  typedef struct {
    logic [7:0] addr;
    int         due;
  } wr_t;

  vec_t tbl[7];
  wr_t  sbq[$];
  int   tests = 0;
  int   fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  function automatic logic [7:0] model_addr(input vec_t v, input int k);
    int i;
    i = k % int'(v.len);
    return 8'(int'(v.base) + i * int'(v.stride));
  endfunction

  task automatic run_cfg(input vec_t v);
    int         total, k, t0, done_at, reads_seen;
    bit         rv_exp, busy_exp, stp, completed;
    logic [7:0] last_rd;
    total      = v.refuse ? 0 : int'(v.len) * int'(v.passes);
    k          = 0;
    reads_seen = 0;
    last_rd    = '0;
    completed  = 1'b0;
    sbq.delete();
    @(negedge clk);
    cfg_base   = v.base;
    cfg_len    = v.len;
    cfg_stride = v.stride;
    cfg_passes = v.passes;
    start      = 1'b1;
    abort      = 1'b0;
    step       = 1'b0;
    t0         = cyc;
    done_at    = (!v.refuse && total == 0) ? t0 + 2 : -1;
    for (int n = 0; n < BUDGET && !completed; n++) begin
      @(negedge clk);
      start    = 1'b0;
      rv_exp   = !v.refuse && (k < total);
      busy_exp = !v.refuse && !(done_at >= 0 && cyc >= done_at);
      check("rd_valid", 32'(rd_valid), 32'(rv_exp));
      check("busy", 32'(busy), 32'(busy_exp));
      check("done", 32'(done), 32'(done_at == cyc));
      check("err", 32'(err), 32'(v.refuse));
      if (sbq.size() > 0 && sbq[0].due == cyc) begin
        check("wr_valid", 32'(wr_valid), 32'd1);
        check("wr_addr", 32'(wr_addr), 32'(sbq[0].addr));
        void'(sbq.pop_front());
      end else begin
        check("wr_valid_idle", 32'(wr_valid), 32'd0);
      end
      if (rv_exp) begin
        check("rd_addr", 32'(rd_addr), 32'(model_addr(v, k)));
        check("first_pass", 32'(first_pass), 32'((k / int'(v.len)) == 0));
        check("last_pass", 32'(last_pass), 32'((k / int'(v.len)) == int'(v.passes) - 1));
      end else begin
        check("first_pass_off", 32'(first_pass), 32'd0);
        check("last_pass_off", 32'(last_pass), 32'd0);
      end
      if ((v.refuse && cyc >= t0 + 4) || (done_at >= 0 && cyc >= done_at + 3)) begin
        completed = 1'b1;
      end else begin
        case (v.mode)
          0:       stp = 1'b1;
          1:       stp = ((cyc - t0) % 2) == 1;
          default: stp = 1'($urandom_range(0, 1));
        endcase
        step = stp;
        if (rv_exp && stp) begin
          if (rd_valid) begin
            reads_seen++;
            last_rd = rd_addr;
          end
          sbq.push_back('{addr: model_addr(v, k), due: cyc + int'(WR_LAT)});
          k++;
          if (k == total) done_at = cyc + int'(WR_LAT) + 1;
        end
        if (v.mode == 2 && rv_exp) begin
          start      = 1'($urandom_range(0, 1));
          cfg_base   = 8'($urandom);
          cfg_len    = 8'($urandom);
          cfg_stride = 8'($urandom);
          cfg_passes = 4'($urandom);
        end
      end
    end
    if (!completed) begin
      tests++;
      fails++;
      $display("FAIL timeout: run did not finish within %0d cycles (base 0x%0h)", BUDGET, v.base);
    end
    check("reads_seen", 32'(reads_seen), 32'(v.exp_reads));
    if (v.exp_reads > 0) check("last_rd", 32'(last_rd), 32'(v.exp_last));
    check("sb_empty", 32'(sbq.size()), 32'd0);
    step = 1'b0;
  endtask

  initial begin
    tbl[0] = '{base: 8'd4,   len: 8'd3, stride: 8'd2, passes: 4'd2, mode: 0, refuse: 1'b0, exp_reads: 6,  exp_last: 8'd8};
    tbl[1] = '{base: 8'd4,   len: 8'd3, stride: 8'd2, passes: 4'd2, mode: 1, refuse: 1'b0, exp_reads: 6,  exp_last: 8'd8};
    tbl[2] = '{base: 8'd9,   len: 8'd0, stride: 8'd1, passes: 4'd3, mode: 0, refuse: 1'b0, exp_reads: 0,  exp_last: 8'd0};
`ifdef PSUM_ADDR_GEN_BOUNDS_EN
    tbl[3] = '{base: 8'd250, len: 8'd4, stride: 8'd3, passes: 4'd1, mode: 0, refuse: 1'b1, exp_reads: 0,  exp_last: 8'd0};
`else
    tbl[3] = '{base: 8'd250, len: 8'd4, stride: 8'd3, passes: 4'd1, mode: 0, refuse: 1'b0, exp_reads: 4,  exp_last: 8'd3};
`endif
    tbl[4] = '{base: 8'd7,   len: 8'd5, stride: 8'd1, passes: 4'd0, mode: 0, refuse: 1'b0, exp_reads: 0,  exp_last: 8'd0};
    tbl[5] = '{base: 8'h10,  len: 8'd5, stride: 8'd7, passes: 4'd3, mode: 2, refuse: 1'b0, exp_reads: 15, exp_last: 8'h2c};
    tbl[6] = '{base: 8'd255, len: 8'd1, stride: 8'd0, passes: 4'd4, mode: 0, refuse: 1'b0, exp_reads: 4,  exp_last: 8'd255};

    rst        = 1'b1;
    start      = 1'b0;
    abort      = 1'b0;
    step       = 1'b0;
    cfg_base   = '0;
    cfg_len    = '0;
    cfg_stride = '0;
    cfg_passes = '0;
    repeat (2) @(negedge clk);
    check("rst_rd_valid", 32'(rd_valid), 32'd0);
    check("rst_rd_addr", 32'(rd_addr), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_wr_valid", 32'(wr_valid), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 7; i++) run_cfg(tbl[i]);

    // Abort after the second accepted step: only the first write escapes.
    @(negedge clk);
    cfg_base = 8'd4; cfg_len = 8'd3; cfg_stride = 8'd2; cfg_passes = 4'd2;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("ab_rd0", 32'(rd_addr), 32'd4);
    step = 1'b1;
    @(negedge clk);
    check("ab_rd1", 32'(rd_addr), 32'd6);
    @(negedge clk);
    check("ab_wr0_valid", 32'(wr_valid), 32'd1);
    check("ab_wr0_addr", 32'(wr_addr), 32'd4);
    step  = 1'b0;
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("ab_busy", 32'(busy), 32'd0);
    check("ab_rd_valid", 32'(rd_valid), 32'd0);
    check("ab_rd_addr", 32'(rd_addr), 32'd0);
    check("ab_wr_valid", 32'(wr_valid), 32'd0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("ab_post_wr", 32'(wr_valid), 32'd0);
      check("ab_post_done", 32'(done), 32'd0);
    end
    run_cfg(tbl[0]);

    // Abort together with start in IDLE: start is ignored.
    @(negedge clk);
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    check("abst_busy", 32'(busy), 32'd0);
    check("abst_rd_valid", 32'(rd_valid), 32'd0);
    @(negedge clk);
    check("abst_busy2", 32'(busy), 32'd0);

    // Reset mid-run with writes in flight.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    step  = 1'b1;
    repeat (2) @(negedge clk);
    check("rs_pre_wr", 32'(wr_valid), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("rs_rd_valid", 32'(rd_valid), 32'd0);
    check("rs_rd_addr", 32'(rd_addr), 32'd0);
    check("rs_busy", 32'(busy), 32'd0);
    check("rs_wr_valid", 32'(wr_valid), 32'd0);
    check("rs_wr_addr", 32'(wr_addr), 32'd0);
    check("rs_first", 32'(first_pass), 32'd0);
    check("rs_last", 32'(last_pass), 32'd0);
    check("rs_done", 32'(done), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("rs_post_wr", 32'(wr_valid), 32'd0);
      check("rs_post_busy", 32'(busy), 32'd0);
      check("rs_post_done", 32'(done), 32'd0);
    end
    step = 1'b0;
    run_cfg(tbl[1]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
